hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline control unit for the 5-stage MIPS core. It generates the stall and clear/flush enables that drive the inter-stage pipeline registers and the operand-forwarding selects for the D and E stages. It also sequences the multi-cycle divider through a small FSM. It sits beside the datapath, consuming register indices and control bits from D/E/M/W and driving the `stall_*`/`flush_*` inputs of the stage registers.

## Interface
- `REG_W`, default 5: register-index width.
- `clk`  in  1  core clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `rs_d`, `rt_d`  in  REG_W  source registers in D.
- `rs_e`, `rt_e`  in  REG_W  source registers in E.
- `write_reg_e`, `write_reg_m`, `write_reg_w`  in  REG_W  destination registers.
- `reg_write_e`, `reg_write_m`, `reg_write_w`  in  1  destination-write enables.
- `mem_to_reg_e`, `mem_to_reg_m`  in  1  load in E / M.
- `branch_d`  in  1  branch/jr resolving in D.
- `div_e`  in  1  divide instruction in E.
- `div_ready`  in  1  divider result valid (single-cycle pulse).
- `exc_m`  in  1  exception committing in M.
- `stall_f`, `stall_d`, `stall_e`  out  1  hold-enables for the PC, D and E registers.
- `flush_d`, `flush_e`, `flush_m`  out  1  clear-enables for the D, E and M registers.
- `fwd_a_d`, `fwd_b_d`  out  1  D-stage forward select from the M-stage ALU result.
- `fwd_a_e`, `fwd_b_e`  out  2  E-stage forward select (00 RF, 01 W result, 10 M ALU result).
- `div_start`  out  1  one-cycle start pulse to the divider.
- `div_cancel`  out  1  one-cycle abort pulse to the divider.

## Operation
- Register 0 never matches for forwarding or hazard purposes.
- **E-stage forwarding:** `fwd_a_e` = 10 if `rs_e`==`write_reg_m` and `reg_write_m` is set. Otherwise 01 if `rs_e`==`write_reg_w` and `reg_write_w` is set. Otherwise 00. M has priority over W. `fwd_b_e` follows the same rule on `rt_e`.
- **D-stage forwarding:** `fwd_a_d` = (`rs_d`==`write_reg_m`) & `reg_write_m`. `fwd_b_d` follows the same rule on `rt_d`.
- **lwstall:** `mem_to_reg_e` & (`rt_e`==`rs_d` | `rt_e`==`rt_d`).
- **brstall:** `branch_d` & one of:
  - `reg_write_e` with `write_reg_e` equal to `rs_d`/`rt_d`;
  - `mem_to_reg_m` with `write_reg_m` equal to `rs_d`/`rt_d`.
- **Divider FSM:** states IDLE, BUSY, DONE; reset state is IDLE.
  - IDLE with `div_e` and no `exc_m`: `div_start`=1, go to BUSY.
  - BUSY: wait for `div_ready`; on `div_ready` go to DONE.
  - DONE: unconditionally go to IDLE. `div_e` seen in DONE does not restart the divider.
- **divstall:** (IDLE & `div_e`) | BUSY. While divstall is asserted: `stall_f`=`stall_d`=`stall_e`=1 and `flush_m`=1 (bubble into M).
- **Stall and flush outputs:**
  - `stall_f` = `stall_d` = lwstall | brstall | divstall.
  - `flush_e` = (lwstall | brstall) & !divstall. The E register is held, not cleared, during a divide.
- **Exception (highest priority):** when `exc_m` is set:
  - `flush_d`=`flush_e`=`flush_m`=1 and all stalls are 0;
  - the FSM goes to IDLE;
  - `div_cancel`=1 if the state is BUSY or DONE.
- `flush_d`=0 except on `exc_m`.
- `div_ready` and `exc_m` in the same cycle: the exception wins and the FSM goes to IDLE. `div_cancel` pulses.
- `div_ready` while IDLE or DONE: ignored.

## Timing
- Only the FSM state is registered. All outputs are combinational from the inputs and the state: zero-cycle latency.
- **Divide sequence:** the start cycle and every BUSY cycle stall the pipeline.
  - The stall is still asserted in the BUSY cycle in which `div_ready` arrives.
  - The first unstalled cycle is DONE, one cycle after `div_ready`.
- **Reset:** `rst` forces IDLE immediately, without waiting for a clock edge. While `rst` is held:
  - `div_start`=0, `div_cancel`=0;
  - all divstall-derived terms are 0;
  - hazard and forwarding outputs still follow their inputs.
- **Reset mid-divide:** the FSM returns to IDLE with no `div_cancel` pulse. The divider has its own reset.

## Structure
- Shared package `cpu_pkg` holds:
  - forward-select constants `FWD_RF`=2'b00, `FWD_WB`=2'b01, `FWD_MEM`=2'b10;
  - the `div_state_t` enum (IDLE, BUSY, DONE);
  - `REG_W`.
- One sub-module, `div_seq`: the divider FSM. Inputs are `clk`, `rst`, `div_e`, `div_ready`, `exc_m`. Outputs are `divstall`, `div_start`, `div_cancel`.
- Forwarding and stall logic stay combinational in `hazard_ctrl`.

## Test plan
- **Forwarding:** `rs_e`=3, `write_reg_m`=3, `write_reg_w`=3, both write enables set → `fwd_a_e`=10. Clear `reg_write_m` → 01. Set `rs_e`=0 → 00.
- **Load-use:** `mem_to_reg_e`=1, `rt_e`=5, `rs_d`=5 → `stall_f`=`stall_d`=1, `flush_e`=1, `stall_e`=0.
- **Branch hazard:** `branch_d`=1, `rs_d`=7, `write_reg_m`=7, `mem_to_reg_m`=1 → stall asserted. Same case with `mem_to_reg_m`=0 and `reg_write_m`=1 → no stall, `fwd_a_d`=1.
- **Divide:** `div_e`=1 held, `div_ready` pulses 4 cycles after start → `div_start` pulses once. `stall_f`/`stall_d`/`stall_e`=1 and `flush_m`=1 for 5 cycles. Next cycle is DONE with no stall and no second `div_start`.
- **Divide plus load-use:** `div_e`=1 together with lwstall conditions → `flush_e`=0 and `stall_e`=1 throughout the divide.
- **Exception and reset:** `exc_m` in cycle 2 of BUSY → `div_cancel`=1, all flushes 1, stalls 0, FSM in IDLE next cycle. `div_ready` in the same cycle is ignored. Asserting `rst` asynchronously mid-BUSY → state is IDLE immediately, `div_cancel`=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the pipeline control logic: register-index width,
// forward-select encodings and the divider sequencer state type.
package cpu_pkg;

  localparam int REG_W = 5;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } div_state_t;

endpackage

// File: rtl/div_seq.sv
// Multi-cycle divider sequencer: issues the start pulse, holds the pipeline
// while the divider works, and aborts it when an exception commits.
module div_seq
  import cpu_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic div_e,
  input  logic div_ready,
  input  logic exc_m,
  output logic divstall,
  output logic div_start,
  output logic div_cancel
);

  div_state_t state_q;
  div_state_t state_d;

  // State register; reset returns to IDLE without waiting for a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a committing exception always drops back to IDLE.
  always_comb begin
    state_d = state_q;
    if (exc_m) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (div_e) begin
            state_d = BUSY;
          end else begin
            state_d = IDLE;
          end
        end
        BUSY: begin
          if (div_ready) begin
            state_d = DONE;
          end else begin
            state_d = BUSY;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Output decode; everything is quiet while reset is held so a reset
  // mid-divide never produces a cancel pulse.
  always_comb begin
    divstall   = 1'b0;
    div_start  = 1'b0;
    div_cancel = 1'b0;
    if (rst) begin
      divstall   = 1'b0;
      div_start  = 1'b0;
      div_cancel = 1'b0;
    end else begin
      divstall   = ((state_q == IDLE) && div_e) || (state_q == BUSY);
      div_start  = (state_q == IDLE) && div_e && !exc_m;
      div_cancel = exc_m && ((state_q == BUSY) || (state_q == DONE));
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit for the 5-stage core: operand forwarding selects,
// load-use / branch / divide stalls, and exception flushes.
module hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int REG_W = cpu_pkg::REG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] rs_d,
  input  logic [REG_W-1:0] rt_d,
  input  logic [REG_W-1:0] rs_e,
  input  logic [REG_W-1:0] rt_e,
  input  logic [REG_W-1:0] write_reg_e,
  input  logic [REG_W-1:0] write_reg_m,
  input  logic [REG_W-1:0] write_reg_w,
  input  logic             reg_write_e,
  input  logic             reg_write_m,
  input  logic             reg_write_w,
  input  logic             mem_to_reg_e,
  input  logic             mem_to_reg_m,
  input  logic             branch_d,
  input  logic             div_e,
  input  logic             div_ready,
  input  logic             exc_m,
  output logic             stall_f,
  output logic             stall_d,
  output logic             stall_e,
  output logic             flush_d,
  output logic             flush_e,
  output logic             flush_m,
  output logic             fwd_a_d,
  output logic             fwd_b_d,
  output logic [1:0]       fwd_a_e,
  output logic [1:0]       fwd_b_e,
  output logic             div_start,
  output logic             div_cancel
);

  // Register 0 is hard-wired, so it never creates a dependency.
  function automatic logic reg_hit(input logic [REG_W-1:0] a,
                                   input logic [REG_W-1:0] b,
                                   input logic             en);
    return en && (a != {REG_W{1'b0}}) && (a == b);
  endfunction

  function automatic logic [1:0] fwd_sel_e(input logic [REG_W-1:0] src,
                                           input logic [REG_W-1:0] wr_m,
                                           input logic             we_m,
                                           input logic [REG_W-1:0] wr_w,
                                           input logic             we_w);
    if (reg_hit(src, wr_m, we_m)) begin
      return FWD_MEM;
    end else if (reg_hit(src, wr_w, we_w)) begin
      return FWD_WB;
    end else begin
      return FWD_RF;
    end
  endfunction

  logic divstall_s;
  logic lwstall_s;
  logic brstall_s;

  div_seq u_div_seq (
    .clk        (clk),
    .rst        (rst),
    .div_e      (div_e),
    .div_ready  (div_ready),
    .exc_m      (exc_m),
    .divstall   (divstall_s),
    .div_start  (div_start),
    .div_cancel (div_cancel)
  );

  // Forwarding selects for the D-stage comparator and the E-stage ALU.
  always_comb begin
    fwd_a_d = reg_hit(rs_d, write_reg_m, reg_write_m);
    fwd_b_d = reg_hit(rt_d, write_reg_m, reg_write_m);
    fwd_a_e = fwd_sel_e(rs_e, write_reg_m, reg_write_m, write_reg_w, reg_write_w);
    fwd_b_e = fwd_sel_e(rt_e, write_reg_m, reg_write_m, write_reg_w, reg_write_w);
  end

  // Load-use and branch-operand hazard detection.
  always_comb begin
    lwstall_s = mem_to_reg_e &&
                (reg_hit(rt_e, rs_d, 1'b1) || reg_hit(rt_e, rt_d, 1'b1));
    brstall_s = branch_d &&
                (reg_hit(write_reg_e, rs_d, reg_write_e) ||
                 reg_hit(write_reg_e, rt_d, reg_write_e) ||
                 reg_hit(write_reg_m, rs_d, mem_to_reg_m) ||
                 reg_hit(write_reg_m, rt_d, mem_to_reg_m));
  end

  // Stall/flush enables; during a divide E is held rather than bubbled.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_m = 1'b0;
    if (exc_m) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
      flush_m = 1'b1;
    end else begin
      stall_f = lwstall_s || brstall_s || divstall_s;
      stall_d = lwstall_s || brstall_s || divstall_s;
      stall_e = divstall_s;
      flush_e = (lwstall_s || brstall_s) && !divstall_s;
      flush_m = divstall_s;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: per-cycle comparison against a
// rule-level model, plus directed cases with hand-computed expectations.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs_d, rt_d, rs_e, rt_e, write_reg_e, write_reg_m, write_reg_w;
  logic       reg_write_e, reg_write_m, reg_write_w;
  logic       mem_to_reg_e, mem_to_reg_m, branch_d, div_e, div_ready, exc_m;
  logic       stall_f, stall_d, stall_e, flush_d, flush_e, flush_m;
  logic       fwd_a_d, fwd_b_d, div_start, div_cancel;
  logic [1:0] fwd_a_e, fwd_b_e;

  int n_pass  = 0;
  int n_total = 0;

  hazard_ctrl dut (
    .clk(clk), .rst(rst), .rs_d(rs_d), .rt_d(rt_d), .rs_e(rs_e), .rt_e(rt_e),
    .write_reg_e(write_reg_e), .write_reg_m(write_reg_m), .write_reg_w(write_reg_w),
    .reg_write_e(reg_write_e), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
    .mem_to_reg_e(mem_to_reg_e), .mem_to_reg_m(mem_to_reg_m), .branch_d(branch_d),
    .div_e(div_e), .div_ready(div_ready), .exc_m(exc_m),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e),
    .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m),
    .fwd_a_d(fwd_a_d), .fwd_b_d(fwd_b_d), .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e),
    .div_start(div_start), .div_cancel(div_cancel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Model of the divide progress: "running" from start until ready, then one
  // "finishing" cycle in which nothing may restart.
  bit m_running  = 1'b0;
  bit m_finishing = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_running <= 1'b0; m_finishing <= 1'b0;
    end else if (exc_m) begin
      m_running <= 1'b0; m_finishing <= 1'b0;
    end else if (m_running) begin
      m_running <= !div_ready; m_finishing <= div_ready;
    end else if (m_finishing) begin
      m_finishing <= 1'b0;
    end else begin
      m_running <= div_e;
    end
  end

  function automatic bit dep(input int a, input int b, input bit en);
    return en && a != 0 && a == b;
  endfunction

  function automatic int fwd_e(input int src);
    if (dep(src, write_reg_m, reg_write_m)) return 2;
    if (dep(src, write_reg_w, reg_write_w)) return 1;
    return 0;
  endfunction

  function automatic logic [15:0] model_vec();
    bit lw, br, ds, idle, sf, se, fd, fe, fm, st, cn;
    lw = mem_to_reg_e && (dep(rt_e, rs_d, 1) || dep(rt_e, rt_d, 1));
    br = branch_d && (dep(write_reg_e, rs_d, reg_write_e) || dep(write_reg_e, rt_d, reg_write_e) ||
                      dep(write_reg_m, rs_d, mem_to_reg_m) || dep(write_reg_m, rt_d, mem_to_reg_m));
    idle = !m_running && !m_finishing;
    ds = !rst && ((idle && div_e) || m_running);
    if (exc_m) begin
      sf = 0; se = 0; fd = 1; fe = 1; fm = 1;
    end else begin
      sf = lw || br || ds; se = ds; fd = 0; fe = (lw || br) && !ds; fm = ds;
    end
    st = !rst && !exc_m && idle && div_e;
    cn = !rst && exc_m && !idle;
    return {2'b00, sf, sf, se, fd, fe, fm,
            dep(rs_d, write_reg_m, reg_write_m), dep(rt_d, write_reg_m, reg_write_m),
            2'(fwd_e(rs_e)), 2'(fwd_e(rt_e)), st, cn};
  endfunction

  wire [15:0] dut_vec = {2'b00, stall_f, stall_d, stall_e, flush_d, flush_e, flush_m,
                         fwd_a_d, fwd_b_d, fwd_a_e, fwd_b_e, div_start, div_cancel};

  always @(negedge clk) chk("cycle", dut_vec, model_vec());

  task automatic clear();
    rs_d = 5'd0; rt_d = 5'd0; rs_e = 5'd0; rt_e = 5'd0;
    write_reg_e = 5'd0; write_reg_m = 5'd0; write_reg_w = 5'd0;
    reg_write_e = 1'b0; reg_write_m = 1'b0; reg_write_w = 1'b0;
    mem_to_reg_e = 1'b0; mem_to_reg_m = 1'b0; branch_d = 1'b0;
    div_e = 1'b0; div_ready = 1'b0; exc_m = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    int n_stall, n_start, n_bad;
    rst = 1'b1;
    clear();
    #1 chk("reset_outputs", dut_vec, 16'h0000);
    tick();
    rst = 1'b0;
    tick();

    // E-stage forwarding priority
    rs_e = 5'd3; write_reg_m = 5'd3; write_reg_w = 5'd3; reg_write_m = 1'b1; reg_write_w = 1'b1;
    #1 chk("fwd_mem", 16'(fwd_a_e), 16'h0002);
    tick(); reg_write_m = 1'b0;
    #1 chk("fwd_wb", 16'(fwd_a_e), 16'h0001);
    tick(); rs_e = 5'd0;
    #1 chk("fwd_r0", 16'(fwd_a_e), 16'h0000);
    tick(); clear(); rt_e = 5'd9; write_reg_m = 5'd9; reg_write_m = 1'b1;
    #1 chk("fwd_b_mem", 16'(fwd_b_e), 16'h0002);

    // load-use, and the register-0 boundary
    tick(); clear(); mem_to_reg_e = 1'b1; rt_e = 5'd5; rs_d = 5'd5;
    #1 chk("lwstall", {12'h0, stall_f, stall_d, flush_e, stall_e}, 16'h000E);
    tick(); rt_e = 5'd0; rs_d = 5'd0;
    #1 chk("lw_r0", {12'h0, stall_f, stall_d, flush_e, stall_e}, 16'h0000);

    // branch hazards
    tick(); clear(); branch_d = 1'b1; rs_d = 5'd7; write_reg_m = 5'd7; mem_to_reg_m = 1'b1;
    #1 chk("br_load_m", {14'h0, stall_f, flush_e}, 16'h0003);
    tick(); mem_to_reg_m = 1'b0; reg_write_m = 1'b1;
    #1 chk("br_alu_m", {14'h0, stall_f, fwd_a_d}, 16'h0001);
    tick(); clear(); branch_d = 1'b1; rt_d = 5'd4; write_reg_e = 5'd4; reg_write_e = 1'b1;
    #1 chk("br_e", 16'(stall_d), 16'h0001);

    // divide, ready four cycles after start
    tick(); clear();
    n_stall = 0; n_start = 0;
    for (int i = 0; i < 7; i++) begin
      div_e = (i <= 5); div_ready = (i == 4);
      #1;
      if (stall_f && stall_d && stall_e && flush_m) n_stall++;
      if (div_start) n_start++;
      if (i == 5) chk("div_done_free", {14'h0, stall_f, div_start}, 16'h0000);
      tick();
    end
    chk("div_stall_cycles", 16'(n_stall), 16'd5);
    chk("div_start_count", 16'(n_start), 16'd1);

    // divide overlapping a load-use: E held, never flushed
    clear(); mem_to_reg_e = 1'b1; rt_e = 5'd5; rs_d = 5'd5;
    n_bad = 0;
    for (int i = 0; i < 6; i++) begin
      div_e = (i <= 4); div_ready = (i == 4);
      #1;
      if (i <= 4 && !(stall_e && !flush_e)) n_bad++;
      if (i == 5) chk("div_lw_after", {14'h0, flush_e, stall_e}, 16'h0002);
      tick();
    end
    chk("div_lw_hold", 16'(n_bad), 16'd0);

    // exception in the second BUSY cycle, with div_ready in the same cycle
    clear(); div_e = 1'b1;
    #1 chk("exc_start", 16'(div_start), 16'h0001);
    tick(); div_e = 1'b0;
    tick(); exc_m = 1'b1; div_ready = 1'b1;
    #1 chk("exc_cancel", {8'h0, div_cancel, flush_d, flush_e, flush_m, 1'b0, stall_f, stall_d, stall_e},
           16'h00F0);
    tick(); exc_m = 1'b0; div_ready = 1'b0; div_e = 1'b1;
    #1 chk("exc_idle", 16'(div_start), 16'h0001);

    // asynchronous reset in the middle of BUSY
    tick(); div_e = 1'b1; rs_e = 5'd3; write_reg_m = 5'd3; reg_write_m = 1'b1;
    #1 chk("busy_stall", 16'(stall_e), 16'h0001);
    rst = 1'b1;
    #1 chk("rst_async", {12'h0, div_cancel, div_start, stall_e, stall_f}, 16'h0000);
    chk("rst_fwd", 16'(fwd_a_e), 16'h0002);
    tick(); rst = 1'b0;
    #1 chk("rst_idle", 16'(div_start), 16'h0001);
    tick(); clear(); div_ready = 1'b1;
    tick(); div_ready = 1'b0;
    tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
